leaf_output_packetizer: RTL and testbench

Transmit-side packetizer for a leaf: accepts wide user output words over a valid/ack handshake and serializes each word into fixed-size BFT packets. Each packet carries the configured destination leaf/port, a wrapping BRAM address and one payload slice. Output is gated by credit-based flow control against the receiving leaf's input buffer. It sits between the user operator's output stream and the leaf's `dout_leaf_interface2bft` path, in the 400 MHz interface domain.

---
 rtl/leaf_output_packetizer.sv | 130 +++++++++++++
 tb/tb_leaf_output_packetizer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/leaf_output_packetizer.sv
// leaf_output_packetizer: serializes wide user output words into BFT packets.
// Each packet carries {valid, leaf, port, wrapping BRAM addr, payload slice}.
// Emission is gated by credits that mirror free space in the receiver buffer.
module leaf_output_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int DATA_USER_OUT_TOTAL   = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LEAF_BITS-1:0]       dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]       dest_port,
    input  logic [DATA_USER_OUT_TOTAL-1:0] din_leaf_user2interface,
    input  logic                           vld_user2interface,
    output logic                           ack_interface2user,
    input  logic                           credit_update,
    input  logic                           resend,
    output logic [PACKET_BITS-1:0]         dout_leaf_interface2bft,
    output logic                           stall_condition,
    output logic [31:0]                    full_cnt
);

    localparam int NUM_BEATS = DATA_USER_OUT_TOTAL / PAYLOAD_BITS;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int CREDIT_W  = NUM_ADDR_BITS + 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t                           r_state;
    state_t                           w_state_next;
    logic [DATA_USER_OUT_TOTAL-1:0]   r_shift;
    logic [NUM_LEAF_BITS-1:0]         r_leaf;
    logic [NUM_PORT_BITS-1:0]         r_port;
    logic [NUM_ADDR_BITS-1:0]         r_addr;
    logic [CREDIT_W-1:0]              r_credits;
    logic [CREDIT_W-1:0]              w_credits_next;
    logic [31:0]                      w_credit_sum;
    logic [BEAT_W-1:0]                r_beat;
    logic [PACKET_BITS-1:0]           r_dout;
    logic [31:0]                      r_full_cnt;
    logic                             w_accept;
    logic                             w_emit;
    logic                             w_stall;
    logic [PACKET_BITS-1:0]           w_packet;

    assign w_packet                = {1'b1, r_leaf, r_port, r_addr, r_shift[PAYLOAD_BITS-1:0]};
    assign dout_leaf_interface2bft = r_dout;
    assign stall_condition         = w_stall;
    assign full_cnt                = r_full_cnt;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state, handshake and emit/stall decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held (no latch).
        w_state_next       = r_state;
        ack_interface2user = 1'b0;
        w_accept           = 1'b0;
        w_emit             = 1'b0;
        w_stall            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ack_interface2user = 1'b1;
                if (vld_user2interface) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_credits != '0 && !resend) begin
                    w_emit = 1'b1;
                    if (r_beat == LAST_BEAT) w_state_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Credit arithmetic: return and consume in one step, then saturate at buffer depth.
    always_comb begin
        w_credit_sum = 32'(r_credits)
                     + (credit_update ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0)
                     - (w_emit ? 32'd1 : 32'd0);
        w_credits_next = (w_credit_sum > 32'(CREDIT_MAX)) ? CREDIT_MAX
                                                          : w_credit_sum[CREDIT_W-1:0];
    end

    // Word capture and beat serialization; frozen on cycles without an emit.
    always_ff @(posedge clk) begin
        // NOTE: the payload path carries no reset; the FSM reset alone keeps stale data from being emitted.
        if (w_accept) begin
            r_shift <= din_leaf_user2interface;
            r_leaf  <= dest_leaf;
            r_port  <= dest_port;
            r_beat  <= '0;
        end else if (w_emit) begin
            r_shift <= r_shift >> PAYLOAD_BITS;
            r_beat  <= r_beat + BEAT_W'(1);
        end
    end

    // Packet output register, address, credits and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout     <= '0;
            r_addr     <= '0;
            r_credits  <= CREDIT_MAX;
            r_full_cnt <= '0;
        end else begin
            r_dout    <= w_emit ? w_packet : '0;
            r_credits <= w_credits_next;
            if (w_emit)  r_addr     <= r_addr + NUM_ADDR_BITS'(1);
            if (w_stall) r_full_cnt <= r_full_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_leaf_output_packetizer.sv
// Bench for leaf_output_packetizer: directed and randomized steps, each cycle
// compared against a transaction-level model (beat queue, credit/addr counters).
module tb_leaf_output_packetizer;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   dest_leaf;
    logic [3:0]   dest_port;
    logic [255:0] din;
    logic         vld;
    logic         ack;
    logic         credit_update;
    logic         resend;
    logic [48:0]  dout;
    logic         stall;
    logic [31:0]  full_cnt;

    always #5 clk = ~clk;

    leaf_output_packetizer dut (
        .clk                     (clk),
        .reset                   (reset),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .credit_update           (credit_update),
        .resend                  (resend),
        .dout_leaf_interface2bft (dout),
        .stall_condition         (stall),
        .full_cnt                (full_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] q_beats[$];
    logic [4:0]  m_leaf;
    logic [3:0]  m_port;
    int          m_credits = 128;
    int          m_addr    = 0;
    logic [31:0] m_full    = 0;
    logic [48:0] m_dout    = '0;
    bit          m_valid   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs: check combinational
    // outputs before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        bit busy, emit, exp_stall;
        @(negedge clk);
        busy      = (q_beats.size() != 0);
        exp_stall = busy && (m_credits == 0 || resend);
        emit      = busy && (m_credits > 0) && !resend;
        if (m_valid) begin
            chk("ack", 64'(ack), 64'(!busy));
            chk("stall", 64'(stall), 64'(exp_stall));
        end
        if (reset) begin
            q_beats.delete();
            m_credits = 128;
            m_addr    = 0;
            m_full    = 0;
            m_dout    = '0;
            m_valid   = 1;
        end else begin
            m_dout = '0;
            if (emit) begin
                m_dout = {1'b1, m_leaf, m_port, 7'(m_addr), q_beats.pop_front()};
                m_addr = (m_addr + 1) % 128;
            end
            if (!busy && vld) begin
                for (int i = 0; i < 8; i++) q_beats.push_back(din[32*i +: 32]);
                m_leaf = dest_leaf;
                m_port = dest_port;
            end
            m_credits = m_credits + (credit_update ? 64 : 0) - (emit ? 1 : 0);
            if (m_credits > 128) m_credits = 128;
            if (exp_stall) m_full = m_full + 32'd1;
        end
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("dout", 64'(dout), 64'(m_dout));
            chk("full_cnt", 64'(full_cnt), 64'(m_full));
        end
    endtask

    task automatic randomize_word();
        for (int i = 0; i < 8; i++) din[32*i +: 32] = $urandom();
        dest_leaf = 5'($urandom());
        dest_port = 4'($urandom());
    endtask

    int n_pkts;

    initial begin
        reset = 1'b1; vld = 1'b0; credit_update = 1'b0; resend = 1'b0;
        din = '0; dest_leaf = '0; dest_port = '0;

        // Reset and reset values
        cycle(); cycle();
        reset = 1'b0;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_full_cnt", 64'(full_cnt), 64'd0);
        cycle();

        // Directed word: slice i = i, leaf 3, port 2; expect 8 packets, addr 0..7
        for (int i = 0; i < 8; i++) din[32*i +: 32] = 32'(i);
        dest_leaf = 5'd3; dest_port = 4'd2; vld = 1'b1;
        cycle();
        vld = 1'b0; din = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("directed_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'(k), 32'(k)}));
        end
        cycle(); cycle();

        // Back-to-back words with no credit returns: run into credit exhaustion
        vld = 1'b1;
        for (int c = 0; c < 16 * 9 + 12; c++) begin
            randomize_word();
            cycle();
        end
        chk("exhaust_stall", 64'(stall), 64'd1);
        chk("exhaust_dout", 64'(dout), 64'd0);
        // One credit return: exactly 64 more packets before the next stall
        credit_update = 1'b1;
        cycle();
        credit_update = 1'b0;
        n_pkts = 0;
        for (int c = 0; c < 80; c++) begin
            randomize_word();
            cycle();
            if (dout[48]) n_pkts++;
        end
        chk("resume_count", 64'(n_pkts), 64'd64);
        vld = 1'b0;

        // Resend held 5 cycles during beat 3; credit return coincident with emit at full credits
        reset = 1'b1; cycle(); reset = 1'b0;
        randomize_word(); vld = 1'b1;
        cycle();
        vld = 1'b0; credit_update = 1'b1;
        cycle();
        credit_update = 1'b0;
        cycle(); cycle();
        resend = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        resend = 1'b0;
        for (int c = 0; c < 7; c++) cycle();
        chk("resend_full_cnt", 64'(full_cnt), 64'd5);

        // Reset after beat 2, then the next word restarts at addr 0
        randomize_word(); vld = 1'b1;
        cycle();
        vld = 1'b0;
        cycle(); cycle(); cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        cycle(); cycle();
        randomize_word(); vld = 1'b1;
        cycle();
        vld = 1'b0;
        cycle();
        chk("post_reset_addr", 64'(dout[38:32]), 64'd0);
        for (int c = 0; c < 9; c++) cycle();

        // Randomized traffic with sporadic resend and credit returns
        for (int c = 0; c < 500; c++) begin
            randomize_word();
            vld           = 1'($urandom_range(0, 1));
            resend        = ($urandom_range(0, 7) == 0);
            credit_update = ($urandom_range(0, 11) == 0);
            cycle();
        end
        vld = 1'b0; resend = 1'b0; credit_update = 1'b0;
        for (int c = 0; c < 10; c++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
